// File: rtl/transmitter_buffer.sv
// transmitter_buffer: 32-bit word FIFO feeding a byte-wide valid/ready serializer (MSB first).
// Define TRANSMITTER_BUFFER_LSB_FIRST_EN to emit each word least significant byte first.
module transmitter_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [31:0] output_data,
    input  logic        send,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic [7:0]  data,
    output logic        valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic [31:0]   shreg;
    logic [1:0]    idx;
    logic          wr_en, pop, xfer;

    function automatic logic [7:0] first_byte(input logic [31:0] w);
`ifdef TRANSMITTER_BUFFER_LSB_FIRST_EN
        return w[7:0];
`else
        return w[31:24];
`endif
    endfunction

    function automatic logic [31:0] shift_word(input logic [31:0] w);
`ifdef TRANSMITTER_BUFFER_LSB_FIRST_EN
        return {8'h00, w[31:8]};
`else
        return {w[23:0], 8'h00};
`endif
    endfunction

    assign wr_en     = send && !full;
    assign pop       = (state == IDLE) && !empty;
    assign xfer      = valid && tx_ready;
    assign count_nxt = count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
    assign valid     = (state == SEND);
    assign busy      = !empty || (state != IDLE);

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_ptr] <= output_data;
    end

    // full/empty are registered from the next count so IDLE can pop on the edge after a write
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (pop) state_nxt = SEND;
            SEND: if (xfer && idx == 2'd3) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // shreg holds the bytes not yet presented; data keeps its last value while idle
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            idx  <= 2'd0;
            data <= 8'h00;
        end else if (pop) begin
            idx  <= 2'd0;
            data <= first_byte(mem[rd_ptr]);
        end else if (xfer && idx != 2'd3) begin
            idx  <= idx + 2'd1;
            data <= first_byte(shreg);
        end
    end

    always_ff @(posedge CLK) begin
        if (pop)
            shreg <= shift_word(mem[rd_ptr]);
        else if (xfer)
            shreg <= shift_word(shreg);
    end

endmodule
